rom_prog_engine: RTL

- Avalon-MM slave that the NIOS II uses to load game images into the NES PRG/CHR memories. It supersedes the single-shot ROM programmer.
- It adds the following:
  - a register map;
  - an auto-incrementing address pointer;
  - N selectable target regions;
  - a write FIFO with back-pressure;
  - a ready/valid drain to the memory side;
  - a HALT output that holds the NES core while loading.
- It sits between the Avalon bus and the ROM/RAM write ports of the NES top level.

---
 rtl/rom_prog_pkg.sv | 41 ++++
 rtl/rom_prog_if.sv | 29 ++
 rtl/rom_prog_fifo.sv | 45 ++++
 rtl/rom_prog_engine.sv | 132 +++++++++++++
 4 files changed

// File: rtl/rom_prog_pkg.sv
// Shared constants and types for the ROM programming engine: register map,
// CTRL/STATUS bit positions, the FIFO entry layout and drain FSM states.
package rom_prog_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_ADDR   = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int REGION_PRG = 0;
  localparam int REGION_CHR = 1;

  localparam int CTRL_REGION_LSB = 0;
  localparam int CTRL_REGION_W   = 8;
  localparam int CTRL_AINC_BIT   = 8;
  localparam int CTRL_HOLD_BIT   = 9;

  localparam int ST_BUSY_BIT   = 0;
  localparam int ST_ERR_BIT    = 1;
  localparam int ST_LEVEL_LSB  = 8;
  localparam int ST_CNT_LSB    = 16;
  localparam int STW_CLR_CNT   = 0;
  localparam int STW_CLR_ERR   = 1;

  // Entry fields are sized for the widest supported configuration; the
  // engine uses only the low ADDR_W/DATA_W bits.
  localparam int ENTRY_ADDR_W = 32;
  localparam int ENTRY_DATA_W = 16;

  typedef struct packed {
    logic [CTRL_REGION_W-1:0] region;
    logic [ENTRY_ADDR_W-1:0]  addr;
    logic [ENTRY_DATA_W-1:0]  data;
  } fifo_entry_t;

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_PRESENT
  } drain_state_t;

endpackage

// File: rtl/rom_prog_if.sv
// Avalon-MM slave port plus the ready/valid memory-side write port of the
// ROM programming engine.
interface rom_prog_if #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int NUM_REGIONS = 2
);
  logic [1:0]             AVL_ADDR;
  logic                   AVL_CS;
  logic                   AVL_WRITE;
  logic                   AVL_READ;
  logic [31:0]            AVL_WRITEDATA;
  logic [31:0]            AVL_READDATA;
  logic                   AVL_WAITREQUEST;
  logic [ADDR_W-1:0]      ROM_ADDR;
  logic [DATA_W-1:0]      ROM_DATA;
  logic [NUM_REGIONS-1:0] ROM_WE;
  logic                   ROM_READY;

  modport master (
    output AVL_ADDR, AVL_CS, AVL_WRITE, AVL_READ, AVL_WRITEDATA, ROM_READY,
    input  AVL_READDATA, AVL_WAITREQUEST, ROM_ADDR, ROM_DATA, ROM_WE
  );

  modport slave (
    input  AVL_ADDR, AVL_CS, AVL_WRITE, AVL_READ, AVL_WRITEDATA, ROM_READY,
    output AVL_READDATA, AVL_WAITREQUEST, ROM_ADDR, ROM_DATA, ROM_WE
  );
endinterface

// File: rtl/rom_prog_fifo.sv
// Synchronous FIFO with registered storage; head is visible on rdata the
// cycle after it is written. Pointers and level reset asynchronously.
module rom_prog_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/rom_prog_engine.sv
// Avalon-MM register front end that queues {region, addr, data} writes and
// drains them one per cycle to the selected NES memory while halting the core.
module rom_prog_engine
  import rom_prog_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int NUM_REGIONS = 2,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  rom_prog_if.slave  bus,
  output logic       NES_HALT
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [CTRL_REGION_W-1:0] ctrl_region;
  logic                     ctrl_ainc, ctrl_hold;
  logic [ADDR_W-1:0]        ptr;
  logic                     err;
  logic [15:0]              xfer_cnt;

  fifo_entry_t       push_entry, head;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  drain_state_t      state, state_nx;

  logic wr, wr_ctrl, wr_addr, wr_data, wr_status;
  logic data_acc, region_bad, push, xfer;
  logic [31:0] rdata;
  logic unused_bits;

  assign wr        = bus.AVL_CS & bus.AVL_WRITE;
  assign wr_ctrl   = wr & (bus.AVL_ADDR == REG_CTRL);
  assign wr_addr   = wr & (bus.AVL_ADDR == REG_ADDR);
  assign wr_data   = wr & (bus.AVL_ADDR == REG_DATA);
  assign wr_status = wr & (bus.AVL_ADDR == REG_STATUS);

  // Conservative full: a same-cycle pop never lets a push through.
  assign bus.AVL_WAITREQUEST = wr_data & fifo_full;
  assign data_acc   = wr_data & ~fifo_full;
  assign region_bad = int'(ctrl_region) >= NUM_REGIONS;
  assign push       = data_acc & ~region_bad;
  // ROM_WE is non-zero exactly while presenting, so READY alone completes it.
  assign xfer       = (state == DRAIN_PRESENT) & bus.ROM_READY;

  assign push_entry.region = ctrl_region;
  assign push_entry.addr   = ENTRY_ADDR_W'(ptr);
  assign push_entry.data   = ENTRY_DATA_W'(bus.AVL_WRITEDATA[DATA_W-1:0]);

  assign unused_bits = ^{head, bus.AVL_WRITEDATA};

  rom_prog_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (push),
    .wdata (push_entry),
    .pop   (xfer),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ctrl_region <= '0;
      ctrl_ainc   <= 1'b0;
      ctrl_hold   <= 1'b0;
      ptr         <= '0;
      err         <= 1'b0;
      xfer_cnt    <= '0;
      NES_HALT    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_region <= bus.AVL_WRITEDATA[CTRL_REGION_LSB +: CTRL_REGION_W];
        ctrl_ainc   <= bus.AVL_WRITEDATA[CTRL_AINC_BIT];
        ctrl_hold   <= bus.AVL_WRITEDATA[CTRL_HOLD_BIT];
      end
      // Bad-region writes are dropped but still advance the pointer.
      if (wr_addr)                     ptr <= bus.AVL_WRITEDATA[ADDR_W-1:0];
      else if (data_acc && ctrl_ainc)  ptr <= ptr + ADDR_W'(1);
      if (wr_status && bus.AVL_WRITEDATA[STW_CLR_ERR]) err <= 1'b0;
      else if (data_acc && region_bad)                 err <= 1'b1;
      if (wr_status && bus.AVL_WRITEDATA[STW_CLR_CNT]) xfer_cnt <= {15'd0, xfer};
      else if (xfer)                                   xfer_cnt <= xfer_cnt + 16'd1;
      NES_HALT <= ctrl_hold | ~fifo_empty;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= DRAIN_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.ROM_WE   = '0;
    bus.ROM_ADDR = '0;
    bus.ROM_DATA = '0;
    case (state)
      DRAIN_IDLE: begin
        if (push) state_nx = DRAIN_PRESENT;
      end
      DRAIN_PRESENT: begin
        bus.ROM_WE   = NUM_REGIONS'(1) << head.region;
        bus.ROM_ADDR = head.addr[ADDR_W-1:0];
        bus.ROM_DATA = head.data[DATA_W-1:0];
        if (xfer && (fifo_level == LVL_W'(1)) && !push) state_nx = DRAIN_IDLE;
      end
      default: state_nx = DRAIN_IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (bus.AVL_CS && bus.AVL_READ) begin
      case (bus.AVL_ADDR)
        REG_CTRL:   rdata = {22'd0, ctrl_hold, ctrl_ainc, ctrl_region};
        REG_ADDR:   rdata = 32'(ptr);
        REG_STATUS: rdata = {xfer_cnt, 8'(fifo_level), 6'd0, err, ~fifo_empty};
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.AVL_READDATA = rdata;
endmodule
